// File: rtl/regfile_pkg.sv
// Shared constants, register word type and address-width helper for the
// multi-port register file.
package regfile_pkg;

   localparam int XLEN_DEF     = 64;
   localparam int NUM_REGS_DEF = 32;

   typedef logic [XLEN_DEF-1:0] word_t;

   function automatic int addr_width(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: optional forwarding from the current write
// ports (highest port index wins) and hardwired zero for address 0.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int ADDR_W    = 5,
   parameter int NUM_WRITE = 2,
   parameter int BYPASS    = 1
) (
   input  logic [ADDR_W-1:0]           rs_address,
   input  logic [XLEN-1:0]             stored_data,
   input  logic                        stored_busy,
   input  logic [NUM_WRITE-1:0]        reg_write,
   input  logic [NUM_WRITE*ADDR_W-1:0] rd_address,
   input  logic [NUM_WRITE*XLEN-1:0]   write_data,
   output logic [XLEN-1:0]             rs_data,
   output logic                        rs_busy
);

   always_comb begin
      rs_data = stored_data;
      rs_busy = stored_busy;
      // Ascending scan so the highest-index matching port is the last to assign.
      for (int w = 0; w < NUM_WRITE; w++) begin
         if ((BYPASS != 0) && reg_write[w] &&
             (rd_address[w*ADDR_W +: ADDR_W] == rs_address)) begin
            rs_data = write_data[w*XLEN +: XLEN];
            rs_busy = 1'b0;
         end
      end
      if (rs_address == '0) begin
         rs_data = '0;
         rs_busy = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero and a per-register busy
// scoreboard for pending writers.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int NUM_REGS  = NUM_REGS_DEF,
   parameter int NUM_READ  = 2,
   parameter int NUM_WRITE = 2,
   parameter int BYPASS    = 1,
   parameter int ADDR_W    = addr_width(NUM_REGS)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_READ*ADDR_W-1:0]  rs_address,
   output logic [NUM_READ*XLEN-1:0]    rs_data,
   output logic [NUM_READ-1:0]         rs_busy,
   input  logic [NUM_WRITE-1:0]        reg_write,
   input  logic [NUM_WRITE*ADDR_W-1:0] rd_address,
   input  logic [NUM_WRITE*XLEN-1:0]   write_data,
   input  logic                        issue_valid,
   input  logic [ADDR_W-1:0]           issue_rd
);

   logic [XLEN-1:0]     regs_q [NUM_REGS];
   logic [XLEN-1:0]     regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int w = 0; w < NUM_WRITE; w++) begin
         if (reg_write[w] && (rd_address[w*ADDR_W +: ADDR_W] != '0)) begin
            regs_d[rd_address[w*ADDR_W +: ADDR_W]] = write_data[w*XLEN +: XLEN];
            busy_d[rd_address[w*ADDR_W +: ADDR_W]] = 1'b0;
         end
      end
      // Issue is applied after writes: a newly issued producer keeps the register busy.
      if (issue_valid && (issue_rd != '0)) begin
         busy_d[issue_rd] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
      regfile_read_port #(
         .XLEN      (XLEN),
         .ADDR_W    (ADDR_W),
         .NUM_WRITE (NUM_WRITE),
         .BYPASS    (BYPASS)
      ) u_port (
         .rs_address  (rs_address[gi*ADDR_W +: ADDR_W]),
         .stored_data (regs_q[rs_address[gi*ADDR_W +: ADDR_W]]),
         .stored_busy (busy_q[rs_address[gi*ADDR_W +: ADDR_W]]),
         .reg_write   (reg_write),
         .rd_address  (rd_address),
         .write_data  (write_data),
         .rs_data     (rs_data[gi*XLEN +: XLEN]),
         .rs_busy     (rs_busy[gi])
      );
   end

endmodule
